// File: rtl/imem_fetch_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_port_if
//  Description : Fetch request/response, program-load and status signals
//                between an instruction fetch unit and imem_fetch_port.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_fetch_port_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_fault;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          busy;

    // Fetch unit / program loader side
    modport master (
        output req_valid, req_addr, resp_ready, ld_valid, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_data, resp_fault, ld_ready, busy
    );

    // Memory side
    modport slave (
        input  req_valid, req_addr, resp_ready, ld_valid, ld_addr, ld_data,
        output req_ready, resp_valid, resp_data, resp_fault, ld_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_port
//  Description : Synchronous-read instruction memory. Self-clears to NOP_WORD
//                after reset, accepts program words through a load port and
//                serves fetches with 1-cycle latency, flagging misaligned or
//                out-of-range addresses instead of aliasing them.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_fetch_port #(
    parameter int          DEPTH    = 256,
    parameter int          AW       = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_port_if.slave  bus
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);
    localparam logic [31:0]   c_DEPTH32  = 32'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic          r_resp_valid;
    logic [31:0]   r_resp_data;
    logic          r_resp_fault;
    logic [31:0]   r_mem [DEPTH];

    logic          w_busy;
    logic          w_req_ready;
    logic          w_ld_ready;
    logic          w_req_acc;
    logic          w_ld_acc;
    logic          w_fault;
    logic [AW-1:0] w_rd_idx;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [31:0]   w_wr_data;

    // Range check uses the whole word address so high addresses never alias
    assign w_fault   = (bus.req_addr[1:0] != 2'b00) ||
                       ({2'b00, bus.req_addr[31:2]} >= c_DEPTH32);
    assign w_rd_idx  = bus.req_addr[AW+1:2];
    assign w_req_acc = bus.req_valid & w_req_ready;
    assign w_ld_acc  = bus.ld_valid & w_ld_ready;

    // The clear sequence owns the write port; loads are only possible in RUN
    assign w_wr_en   = (r_state == ST_CLEAR) || w_ld_acc;
    assign w_wr_addr = (r_state == ST_CLEAR) ? r_clr_cnt : bus.ld_addr;
    assign w_wr_data = (r_state == ST_CLEAR) ? NOP_WORD  : bus.ld_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; single-stage pipe so a taken response frees the slot
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_ld_ready  = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ld_ready  = 1'b1;
                w_req_ready = !r_resp_valid || bus.resp_ready;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Clear counter walks every index once, then wraps back to zero unused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Memory array write port (not reset; contents are rebuilt by the clear sequence)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Response register; reading before the same-edge write gives read-before-write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_resp_fault <= 1'b0;
        end else if (w_req_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= w_fault;
            r_resp_data  <= w_fault ? NOP_WORD : r_mem[w_rd_idx];
        end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.ld_ready   = w_ld_ready;
    assign bus.busy       = w_busy;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_fault = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_port
//  Description : Self-checking bench for imem_fetch_port. Directed scenarios
//                followed by random traffic, compared cycle by cycle against
//                an array-based behavioural model of the memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_fetch_port;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_fetch_port_if #(.AW(AW)) bus ();

    imem_fetch_port #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_WORD (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_rf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_clear_left = DEPTH;
        m_rv = 1'b0;
        m_rd = 32'h0;
        m_rf = 1'b0;
    endtask

    task automatic drive(input bit rv, input logic [31:0] ra, input bit rr,
                         input bit lv, input logic [AW-1:0] la, input logic [31:0] ld);
        bus.req_valid  = rv;
        bus.req_addr   = ra;
        bus.resp_ready = rr;
        bus.ld_valid   = lv;
        bus.ld_addr    = la;
        bus.ld_data    = ld;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge
    task automatic step();
        bit          exp_busy, exp_rr, exp_lr, acc, ldo;
        logic [31:0] a;
        @(negedge clk);
        exp_busy = (m_clear_left > 0);
        exp_lr   = !exp_busy;
        exp_rr   = !exp_busy && (!m_rv || bus.resp_ready);
        check("busy",       {31'b0, bus.busy},       {31'b0, exp_busy});
        check("ld_ready",   {31'b0, bus.ld_ready},   {31'b0, exp_lr});
        check("req_ready",  {31'b0, bus.req_ready},  {31'b0, exp_rr});
        check("resp_valid", {31'b0, bus.resp_valid}, {31'b0, m_rv});
        if (m_rv) begin
            check("resp_data",  bus.resp_data, m_rd);
            check("resp_fault", {31'b0, bus.resp_fault}, {31'b0, m_rf});
        end
        acc = bus.req_valid && exp_rr;
        ldo = bus.ld_valid && exp_lr;
        if (exp_busy) m_clear_left--;
        if (acc) begin
            a    = bus.req_addr;
            m_rf = (a % 4 != 0) || (a / 4 >= DEPTH);
            m_rd = m_rf ? 32'h0 : m_mem[a / 4];
            m_rv = 1'b1;
        end else if (bus.resp_ready) begin
            m_rv = 1'b0;
        end
        if (ldo) m_mem[bus.ld_addr] = bus.ld_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_resp_data",  bus.resp_data,           32'h0);
        check("rst_resp_fault", {31'b0, bus.resp_fault}, 32'h0);
        check("rst_busy",       {31'b0, bus.busy},       32'h1);
        check("rst_req_ready",  {31'b0, bus.req_ready},  32'h0);
        check("rst_ld_ready",   {31'b0, bus.ld_ready},   32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       a = {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (sel < 8)  a = {27'b0, 3'($urandom_range(0, 7)), 2'b00};
        else if (sel == 8) a = {22'b0, 8'($urandom), 2'($urandom_range(1, 3))};
        else begin
            a = $urandom;
            a[1:0] = 2'b00;
            if (a < 32'h400) a = a | 32'h400;
        end
        return a;
    endfunction

    initial begin
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch held during clear: busy for exactly DEPTH cycles, then reads NOP
        drive(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        repeat (DEPTH + 1) step();
        // Last index, misaligned, and out of range
        drive(1'b1, 32'h3FC, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b1, 32'h2,   1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b1, 32'h400, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0,   1'b1, 1'b0, '0, 32'h0); step(); step();

        // Program load then back-to-back fetches
        drive(1'b0, 32'h0, 1'b1, 1'b1, 8'd0, 32'h2008000A); step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 8'd1, 32'h20090008); step();
        drive(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b1, 32'h4, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0); step(); step();

        // Backpressure for three cycles, then release with a request waiting
        drive(1'b1, 32'h4, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        repeat (3) step();
        drive(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0); step(); step();

        // Same-cycle load and fetch of one index: old word first, new word next
        drive(1'b1, 32'h8, 1'b1, 1'b1, 8'd2, 32'h01095025); step();
        drive(1'b1, 32'h8, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0); step(); step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] la;
            la = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            drive(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), la, $urandom);
            step();
        end

        // Reset while a response is pending drops it and erases the program
        drive(1'b0, 32'h0, 1'b1, 1'b1, 8'd0, 32'hDEADBEEF); step();
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        check("pre_rst_valid", {31'b0, bus.resp_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        repeat (DEPTH) step();
        drive(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
